// File: rtl/riscv_pkg.sv
// Shared core types: fetch FSM states, prefetch entry layout and reset PC.
package riscv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned FETCH_DEPTH = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, decode-side stream and redirect.
interface fetch_unit_if;

  logic                       mem_req;
  logic [riscv_pkg::XLEN-1:0] mem_addr;
  logic                       mem_ready;
  logic                       mem_rvalid;
  logic [riscv_pkg::XLEN-1:0] mem_rdata;
  logic                       instr_valid;
  logic [riscv_pkg::XLEN-1:0] instr;
  logic [riscv_pkg::XLEN-1:0] instr_pc;
  logic                       instr_ready;
  logic                       redirect;
  logic [riscv_pkg::XLEN-1:0] redirect_pc;

  modport master (
    output mem_req, mem_addr,
    input  mem_ready, mem_rvalid, mem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ready, mem_rvalid, mem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int unsigned DEPTH = FETCH_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count
);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, keeps one imem read in flight
// and queues returned words with their PCs for decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t    state_q;
  fetch_state_t    state_n;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_n;
  logic            mem_req_q;
  logic            mem_req_n;
  logic            accept;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_n;
  fetch_entry_t    wentry;
  fetch_entry_t    head;

  assign accept = mem_req_q && bus.mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_n;
  end

  // A redirect with a read in flight must first swallow the stale response.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: state_n = REQ;
      REQ:  if (accept) state_n = bus.redirect ? DROP : WAIT;
      WAIT: begin
        if (bus.mem_rvalid)    state_n = REQ;
        else if (bus.redirect) state_n = DROP;
      end
      DROP: if (bus.mem_rvalid) state_n = REQ;
      default: state_n = IDLE;
    endcase
  end

  // Next-cycle request is decided from next state and next occupancy, so the
  // returned word always has a free slot.
  always_comb begin
    push       = (state_q == WAIT) && bus.mem_rvalid && !bus.redirect;
    pop        = (count != '0) && bus.instr_ready;
    fetch_pc_n = fetch_pc_q;
    count_n    = count + CW'(push) - CW'(pop);
    if (bus.redirect) begin
      fetch_pc_n = bus.redirect_pc & ~32'h3;
      count_n    = '0;
    end else if (push) begin
      fetch_pc_n = fetch_pc_q + 32'd4;
    end
    mem_req_n = (state_n == REQ) && (count_n < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_n;
      mem_req_q  <= mem_req_n;
    end
  end

  assign wentry = '{pc: fetch_pc_q, instr: bus.mem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = fetch_pc_q;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

endmodule
